fifo36_unpack9: RTL and testbench

- Read-side companion for the 15-entry 36-bit SRL16 FIFO.
- Drains 36-bit words via the FIFO's oe/empty interface and unpacks each word into four 9-bit lanes.
- Each lane is 8 data bits plus bit 8 as an end-of-packet marker.
- Lanes are presented one per transfer on an ov/rdy handshake to downstream byte-serial logic (e.g. UART or serial framer).

---
 rtl/fifo36_unpack9.sv | 76 +++++++
 tb/tb_fifo36_unpack9.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo36_unpack9.sv
// Read-side unpacker for a 36-bit FIFO: pops one word at a time and streams it out
// as up to four 9-bit lanes (bit 8 = end-of-packet) on an ov/rdy handshake.
module fifo36_unpack9 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] fifo_pdo,
  input  logic        fifo_empty,
  output logic        fifo_oe,
  output logic [8:0]  dout,
  output logic        ov,
  output logic        eop,
  input  logic        rdy,
  output logic        busy
);

  logic [35:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;
  logic        full_q, full_d;
  logic [1:0]  phys;
  logic        take;
  logic        last;

  // Lane selection and handshake terms.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    phys = MSB_FIRST ? (2'd3 - lane_q) : lane_q;
    dout = 9'd0;
    if (full_q) begin
      unique case (phys)
        2'd0:    dout = word_q[8:0];
        2'd1:    dout = word_q[17:9];
        2'd2:    dout = word_q[26:18];
        default: dout = word_q[35:27];
      endcase
    end
    take = full_q & rdy;
    // A marker ends the word early; lanes behind it are dropped.
    last    = (lane_q == 2'd3) | dout[8];
    fifo_oe = ~rst & ~fifo_empty & (~full_q | (take & last));
    ov      = full_q;
    busy    = full_q;
    eop     = full_q & dout[8];
  end

  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    full_d = full_q;
    if (fifo_oe) begin
      word_d = fifo_pdo;
      lane_d = 2'd0;
      full_d = 1'b1;
    end else if (take && last) begin
      lane_d = 2'd0;
      full_d = 1'b0;
    end else if (take) begin
      lane_d = lane_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= 36'd0;
      lane_q <= 2'd0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_fifo36_unpack9.sv
// Directed bench for fifo36_unpack9: a per-cycle vector table against a small FIFO
// model (MSB_FIRST=1), plus a short hand sequence for an MSB_FIRST=0 instance.
module tb_fifo36_unpack9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [35:0] fifo_pdo;
  logic        fifo_empty;
  logic        fifo_oe;
  logic [8:0]  dout;
  logic        ov, eop, busy;

  logic        rst2   = 1'b1;
  logic        empty2 = 1'b1;
  logic        rdy2   = 1'b1;
  logic [35:0] pdo2   = 36'h0_0000_0201;
  logic        oe2;
  logic [8:0]  dout2;
  logic        ov2, eop2, busy2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Simple FIFO model: show-ahead data, pop on a clock edge with fifo_oe high.
  logic [35:0] mem [16];
  logic [4:0]  wr_ptr = 5'd0;
  logic [4:0]  rd_ptr = 5'd0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_pdo   = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (fifo_oe) rd_ptr <= rd_ptr + 5'd1;
  end

  fifo36_unpack9 #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .fifo_pdo(fifo_pdo), .fifo_empty(fifo_empty),
    .fifo_oe(fifo_oe), .dout(dout), .ov(ov), .eop(eop), .rdy(rdy), .busy(busy)
  );

  fifo36_unpack9 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst2), .fifo_pdo(pdo2), .fifo_empty(empty2),
    .fifo_oe(oe2), .dout(dout2), .ov(ov2), .eop(eop2), .rdy(rdy2), .busy(busy2)
  );

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic push_word(input logic [35:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        push;
    logic [35:0] data;
    logic        ov;
    logic [8:0]  dout;
    logic        oe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic y, input logic p, input logic [35:0] d,
                     input logic o, input logic [8:0] q, input logic e);
    vec_t v;
    v.rst = r; v.rdy = y; v.push = p; v.data = d;
    v.ov = o; v.dout = q; v.oe = e;
    vecs.push_back(v);
  endtask

  // Words built lane by lane {lane3, lane2, lane1, lane0}.
  localparam logic [35:0] W1 = {9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4};
  localparam logic [35:0] W2 = {9'h011, 9'h022, 9'h033, 9'h044};
  localparam logic [35:0] W3 = {9'h0F1, 9'h0E2, 9'h0D3, 9'h0C4};
  localparam logic [35:0] W4 = {9'h055, 9'h166, 9'h077, 9'h188};  // marker on bit 26
  localparam logic [35:0] W5 = {9'h1A5, 9'h0B6, 9'h0C7, 9'h0D8};  // marker on first lane
  localparam logic [35:0] W6 = {9'h021, 9'h032, 9'h043, 9'h054};
  localparam logic [35:0] W7 = {9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD};
  localparam logic [35:0] W8 = {9'h012, 9'h034, 9'h056, 9'h078};

  logic [8:0] lsb_dout [7];
  logic       lsb_ov   [7];
  logic       lsb_oe   [7];

  initial begin
    //  rst rdy push data  ov dout    oe
    add(1, 1, 1, W1,    0, 9'h000, 0);  // c0  reset holds pop off despite data
    add(1, 1, 0, 36'd0, 0, 9'h000, 0);
    add(0, 1, 0, 36'd0, 0, 9'h000, 1);  // c2  first pop
    add(0, 1, 0, 36'd0, 1, 9'h0A1, 0);
    add(0, 1, 0, 36'd0, 1, 9'h0B2, 0);
    add(0, 1, 0, 36'd0, 1, 9'h0C3, 0);
    add(0, 1, 0, 36'd0, 1, 9'h0D4, 0);  // c6  last lane, FIFO empty
    add(0, 1, 1, W2,    0, 9'h000, 1);  // c7  ov dropped, pop W2
    add(0, 1, 1, W3,    1, 9'h011, 0);
    add(0, 1, 0, 36'd0, 1, 9'h022, 0);
    add(0, 1, 0, 36'd0, 1, 9'h033, 0);
    add(0, 1, 0, 36'd0, 1, 9'h044, 1);  // c11 back-to-back pop
    add(0, 1, 0, 36'd0, 1, 9'h0F1, 0);
    add(0, 1, 0, 36'd0, 1, 9'h0E2, 0);
    add(0, 1, 0, 36'd0, 1, 9'h0D3, 0);
    add(0, 1, 1, W4,    1, 9'h0C4, 1);
    add(0, 1, 1, W5,    1, 9'h055, 0);  // c16 marker word
    add(0, 1, 0, 36'd0, 1, 9'h166, 1);  // c17 marker ends word early
    add(0, 1, 1, W6,    1, 9'h1A5, 1);  // c18 single-transfer word
    add(0, 1, 0, 36'd0, 1, 9'h021, 0);  // c19 rdy pattern 1,0,0,1,0,1,0,1
    add(0, 0, 0, 36'd0, 1, 9'h032, 0);
    add(0, 0, 0, 36'd0, 1, 9'h032, 0);
    add(0, 1, 0, 36'd0, 1, 9'h032, 0);
    add(0, 0, 1, W7,    1, 9'h043, 0);
    add(0, 1, 0, 36'd0, 1, 9'h043, 0);
    add(0, 0, 0, 36'd0, 1, 9'h054, 0);  // c25 full, not taking: no pop
    add(0, 1, 1, W8,    1, 9'h054, 1);
    add(0, 1, 0, 36'd0, 1, 9'h0AA, 0);
    add(0, 1, 0, 36'd0, 1, 9'h0BB, 0);
    add(1, 1, 0, 36'd0, 1, 9'h0CC, 0);  // c29 reset mid-word
    add(0, 1, 0, 36'd0, 0, 9'h000, 1);
    add(0, 1, 0, 36'd0, 1, 9'h012, 0);
    add(0, 1, 0, 36'd0, 1, 9'h034, 0);
    add(0, 1, 0, 36'd0, 1, 9'h056, 0);
    add(0, 1, 0, 36'd0, 1, 9'h078, 0);
    add(0, 1, 0, 36'd0, 0, 9'h000, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      rdy = vecs[i].rdy;
      if (vecs[i].push) push_word(vecs[i].data);
      #1;
      check($sformatf("c%0d ov", i),   ov,      vecs[i].ov);
      check($sformatf("c%0d busy", i), busy,    vecs[i].ov);
      check($sformatf("c%0d dout", i), dout,    vecs[i].dout);
      check($sformatf("c%0d eop", i),  eop,     vecs[i].ov & vecs[i].dout[8]);
      check($sformatf("c%0d oe", i),   fifo_oe, vecs[i].oe);
    end

    // Ascending lane order: 0x0_0000_0201 -> 0x001, 0x001, 0x000, 0x000.
    lsb_ov   = '{0, 0, 1, 1, 1, 1, 0};
    lsb_dout = '{9'h000, 9'h000, 9'h001, 9'h001, 9'h000, 9'h000, 9'h000};
    lsb_oe   = '{0, 1, 0, 0, 0, 0, 0};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) empty2 = 1'b0;
      if (k == 1) rst2 = 1'b0;
      if (k == 2) empty2 = 1'b1;
      #1;
      check($sformatf("lsb%0d ov", k),   ov2,   lsb_ov[k]);
      check($sformatf("lsb%0d dout", k), dout2, lsb_dout[k]);
      check($sformatf("lsb%0d oe", k),   oe2,   lsb_oe[k]);
      check($sformatf("lsb%0d eop", k),  eop2,  1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
